in_commutator: RTL

//  Input-side reorder buffer for the radix-4 pipeline FFT. Accepts one complex sample per cycle
//  in natural time order and emits 4-lane parallel words for the first butterfly stage:

---
 rtl/in_commutator_pkg.sv | 24 ++
 rtl/in_commutator_if.sv | 21 ++
 rtl/in_commutator_quarter_buffer.sv | 39 +++
 rtl/in_commutator.sv | 126 ++++++++++++
 4 files changed

// File: rtl/in_commutator_pkg.sv
// Shared FFT constants, lane mapping and reader state type for the input commutator.
package in_commutator_pkg;

    localparam int unsigned FFT_SFPW  = 32;
    localparam int unsigned FFT_N     = 64;
    localparam int unsigned FFT_LOG2N = 6;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_X0   = 3;  // x[n]
    localparam int unsigned LANE_X1   = 2;  // x[n+N/4]
    localparam int unsigned LANE_X2   = 1;  // x[n+N/2]
    localparam int unsigned LANE_X3   = 0;  // x[n+3N/4]

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Quarter q of the frame is presented on lane 3-q of the output word.
    function automatic int unsigned lane_of_quarter(input int unsigned q);
        return NUM_LANES - 1 - q;
    endfunction

endpackage

// File: rtl/in_commutator_if.sv
// Serial-in / 4-lane-out stream bundle between the sample source and the commutator.
interface in_commutator_if #(
    parameter int unsigned NB = 32
);
    logic              start;
    logic              in_valid;
    logic [NB-1:0]     input_data;
    logic              out_valid;
    logic              out_sop;
    logic [4*NB-1:0]   output_data;

    modport master (
        output start, in_valid, input_data,
        input  out_valid, out_sop, output_data
    );

    modport slave (
        input  start, in_valid, input_data,
        output out_valid, out_sop, output_data
    );
endinterface

// File: rtl/in_commutator_quarter_buffer.sv
// One lane of sample storage: 2 banks x N/4 words, one write port, registered read port.
module in_commutator_quarter_buffer
    import in_commutator_pkg::*;
#(
    parameter int unsigned NB = FFT_SFPW,
    parameter int unsigned AW = 4          // {bank, word address}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [NB-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [NB-1:0] rd_data_o
);

    logic [NB-1:0] mem_q [2**AW];
    logic [NB-1:0] rd_data_q;

    // Storage array write; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; holds the last word read when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/in_commutator.sv
// Input reorder buffer: natural-order serial samples -> 4-lane beats for the first radix-4 stage.
module in_commutator
    import in_commutator_pkg::*;
#(
    parameter int unsigned nb    = FFT_SFPW,
    parameter int unsigned N     = FFT_N,
    parameter int unsigned LOG2N = FFT_LOG2N
) (
    input  logic            clk,
    input  logic            reset,
    in_commutator_if.slave  bus
);

    localparam int unsigned QW = LOG2N - 2;

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, wr_pos;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             wr_en, wrap;

    rd_state_e        state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [QW-1:0]    rd_cnt_q, rd_cnt_d;
    logic             rd_en, rd_clr;

    logic             out_valid_q, out_sop_q;
    logic [nb-1:0]    lane_data [NUM_LANES];

    // Write-side position: start realigns the current sample to x[0].
    always_comb begin
        wr_pos    = bus.start ? '0 : wr_cnt_q;
        wr_en     = bus.in_valid && !reset;
        wrap      = wr_en && (wr_pos == LOG2N'(N - 1));
        wr_cnt_d  = bus.start ? '0 : wr_cnt_q;
        if (wr_en) begin
            wr_cnt_d = wr_pos + LOG2N'(1);
        end
        wr_bank_d = wrap ? ~wr_bank_q : wr_bank_q;
    end

    // Reader FSM next state; banks are filled alternately so rd_bank_q always names the oldest.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_en     = 1'b0;
        rd_clr    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                rd_cnt_d = '0;
                if (full_q[rd_bank_q]) begin
                    state_d = RD_READ;
                end
            end
            RD_READ: begin
                rd_en    = 1'b1;
                rd_cnt_d = rd_cnt_q + QW'(1);
                if (rd_cnt_q == '1) begin
                    rd_clr    = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Bank-full flags: the read clear is applied first so a wrap-set on the same bank wins.
    always_comb begin
        full_d = full_q;
        if (rd_clr) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wrap) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Counter, flag, FSM and output-qualifier registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= '0;
            state_q     <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= rd_en;
            out_sop_q   <= rd_en && (rd_cnt_q == '0);
        end
    end

    for (genvar q = 0; q < NUM_LANES; q++) begin : g_lane
        in_commutator_quarter_buffer #(
            .NB (nb),
            .AW (QW + 1)
        ) u_qbuf (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en && (wr_pos[LOG2N-1 -: 2] == 2'(q))),
            .wr_addr_i ({wr_bank_q, wr_pos[QW-1:0]}),
            .wr_data_i (bus.input_data),
            .rd_en_i   (rd_en),
            .rd_addr_i ({rd_bank_q, rd_cnt_q}),
            .rd_data_o (lane_data[q])
        );
        assign bus.output_data[nb*lane_of_quarter(q) +: nb] = lane_data[q];
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;

    a_no_overwrite: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && full_q[wr_bank_q] && !(rd_clr && (rd_bank_q == wr_bank_q))))
        else $error("in_commutator: write into a bank still awaiting readout");

endmodule
